// File: rtl/mem_requester_if.sv
// mem_requester_if: core-side request/response handshake plus the pins toward
// the fixed-latency RAM, bundled for the mem_requester initiator.
// Optional macro MEM_REQUESTER_WRITE_ACK_EN adds the rsp_write flag.
interface mem_requester_if #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 8
);
  // core-side request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_wdata;
  // core-side response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W_DATA-1:0] rsp_data;
`ifdef MEM_REQUESTER_WRITE_ACK_EN
  logic              rsp_write;
`endif
  logic              busy;
  // RAM pins
  logic              ram_write_en;
  logic [W_ADDR-1:0] ram_addr;
  logic [W_DATA-1:0] ram_din;
  logic [W_DATA-1:0] ram_dout;

  // master: the requester itself
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_data, busy, ram_write_en, ram_addr, ram_din
`ifdef MEM_REQUESTER_WRITE_ACK_EN
    , output rsp_write
`endif
  );

  // slave: the core and RAM attached around the requester
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_data, busy, ram_write_en, ram_addr, ram_din
`ifdef MEM_REQUESTER_WRITE_ACK_EN
    , input rsp_write
`endif
  );
endinterface

// File: rtl/mem_requester.sv
// mem_requester: initiator for a fixed-latency RAM that cannot stall.
// Reads are tagged through a LATENCY-deep valid pipe and their data captured
// into a small in-order response FIFO; a credit counter (reads in flight plus
// FIFO occupancy) holds off requests so a returning beat always has a slot.
// Optional macro MEM_REQUESTER_WRITE_ACK_EN: writes also take a credit and
// return an all-zero beat flagged by rsp_write.
module mem_requester #(
  parameter int W_DATA  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rstn,
  mem_requester_if.master bus
);
  localparam int W_ADDR    = $clog2(DEPTH);
  localparam int RSP_DEPTH = LATENCY + 2;
  localparam int W_CNT     = $clog2(RSP_DEPTH + 1);
  localparam int W_PTR     = $clog2(RSP_DEPTH);
  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(RSP_DEPTH);
  localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(RSP_DEPTH - 1);

  logic [W_ADDR-1:0] addr_w;
  logic [W_DATA-1:0] wdata_w;
  logic [W_DATA-1:0] dout_w;
  logic [W_DATA-1:0] push_data;
  logic              acc;
  logic              tag_in;
  logic              tag_out;
  logic              push;
  logic              pop;
  logic              req_ready_w;
  logic              rsp_valid_w;

  logic              rstn_q,   rstn_d;
  logic [W_CNT-1:0]  used_q,   used_d;
  logic [W_CNT-1:0]  cnt_q,    cnt_d;
  logic [W_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0]  rd_ptr_q, rd_ptr_d;

  // FIFO storage is not reset; occupancy and pointers alone define validity
  logic [W_DATA-1:0] fifo_mem [RSP_DEPTH];

  assign addr_w  = bus.req_addr;
  assign wdata_w = bus.req_wdata;
  assign dout_w  = bus.ram_dout;

  // handshake and RAM pins; writes commit at the accepting edge
  assign acc              = bus.req_valid & req_ready_w;
  assign bus.ram_addr     = addr_w;
  assign bus.ram_din      = wdata_w;
  assign bus.ram_write_en = acc & bus.req_write;

  // req_ready depends only on registered state, never on the request itself
  assign req_ready_w   = rstn_q & (used_q != CNT_FULL);
  assign bus.req_ready = req_ready_w;
  assign bus.busy      = (used_q != '0);

  assign rsp_valid_w   = (cnt_q != '0);
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_data  = fifo_mem[rd_ptr_q];
  assign pop           = rsp_valid_w & bus.rsp_ready;
  assign push          = tag_out;

`ifdef MEM_REQUESTER_WRITE_ACK_EN
  logic wr_in;
  logic wr_out;
  logic fifo_wr_mem [RSP_DEPTH];

  // every accepted request, read or write, owes one response beat
  assign tag_in        = acc;
  assign wr_in         = acc & bus.req_write;
  assign push_data     = wr_out ? '0 : dout_w;
  assign bus.rsp_write = fifo_wr_mem[rd_ptr_q];

  // write-flag storage alongside the data entries
  always_ff @(posedge clk) begin
    if (push) fifo_wr_mem[wr_ptr_q] <= wr_out;
  end
`else
  // only reads owe a response beat; writes are posted
  assign tag_in    = acc & ~bus.req_write;
  assign push_data = dout_w;
`endif

  generate
    if (LATENCY == 0) begin : g_no_pipe
      // combinational RAM: data is valid in the accepting cycle itself
      assign tag_out = tag_in;
`ifdef MEM_REQUESTER_WRITE_ACK_EN
      assign wr_out  = wr_in;
`endif
    end else begin : g_pipe
      logic [LATENCY-1:0] tag_q, tag_d;
`ifdef MEM_REQUESTER_WRITE_ACK_EN
      logic [LATENCY-1:0] wr_q, wr_d;

      // write flag travels in lockstep with its tag
      always_comb begin
        wr_d[0] = wr_in;
        for (int i = 1; i < LATENCY; i++) wr_d[i] = wr_q[i-1];
      end

      // write-flag pipe register, cleared so reset drops in-flight writes
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wr_q <= '0;
        else       wr_q <= wr_d;
      end

      assign wr_out = wr_q[LATENCY-1];
`endif

      // shift the tag one stage per cycle; the last stage marks dout valid
      always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
      end

      // tag pipe register, cleared so reset drops in-flight reads
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tag_q <= '0;
        else       tag_q <= tag_d;
      end

      assign tag_out = tag_q[LATENCY-1];
    end
  endgenerate

  // next-state for reset-release flag, FIFO pointers/count and credits
  always_comb begin
    rstn_d   = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    used_d   = used_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // a credit is taken when a tag enters the pipe, returned when its beat leaves
    case ({tag_in, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  // control state; reset discards in-flight work and the queued beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstn_q   <= 1'b0;
      used_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      rstn_q   <= rstn_d;
      used_q   <= used_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // capture RAM data into the FIFO tail when a tagged beat arrives
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // the credit scheme guarantees a free slot for every arriving beat
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (cnt_q == CNT_FULL)));

  // credits never exceed the FIFO size
  a_credit_bound: assert property (@(posedge clk) disable iff (!rstn)
    (used_q <= CNT_FULL));
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed bench with a scoreboard. Instance A runs with
// LATENCY=2 against a behavioural RAM; instance B runs with LATENCY=0.
// Honours MEM_REQUESTER_WRITE_ACK_EN when defined.
`timescale 1ns/1ps
module tb_mem_requester;
  localparam int W_DATA = 8;
  localparam int DEPTH  = 256;
  localparam int W_ADDR = 8;
  localparam int LAT_A  = 2;
  localparam int LAT_B  = 0;
  localparam int RSP_A  = LAT_A + 2;
`ifdef MEM_REQUESTER_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_requester_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) ifa ();
  mem_requester_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) ifb ();

  mem_requester #(.W_DATA(W_DATA), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk (clk), .rstn(rstn), .bus (ifa)
  );
  mem_requester #(.W_DATA(W_DATA), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk (clk), .rstn(rstn), .bus (ifb)
  );

  // behavioural RAM A: read-first, data appears LAT_A cycles after the address
  logic [7:0] mem_a  [DEPTH];
  logic [7:0] pipe_a [LAT_A];
  always @(posedge clk) begin
    if (ifa.ram_write_en) mem_a[ifa.ram_addr] <= ifa.ram_din;
    pipe_a[0] <= mem_a[ifa.ram_addr];
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
  end
  assign ifa.ram_dout = pipe_a[LAT_A-1];

  // behavioural RAM B: combinational read
  logic [7:0] mem_b [DEPTH];
  always @(posedge clk) begin
    if (ifb.ram_write_en) mem_b[ifb.ram_addr] <= ifb.ram_din;
  end
  assign ifb.ram_dout = mem_b[ifb.ram_addr];

  // scoreboard for instance A
  typedef struct packed {
    logic       wr;
    logic [7:0] data;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] ref_mem [DEPTH];
  int vectors     = 0;
  int miscompares = 0;
  int reads_acc   = 0;
  int beats       = 0;
  int b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // negedge: compare any beat taken this cycle, then record any request accepted
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (rstn) begin
      if (ifa.rsp_valid && ifa.rsp_ready) begin
        chk("sb_beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          beats++;
          chk("rsp_data", 32'(ifa.rsp_data), 32'(e.data));
`ifdef MEM_REQUESTER_WRITE_ACK_EN
          chk("rsp_write", 32'(ifa.rsp_write), 32'(e.wr));
`endif
        end
      end
      if (ifa.req_valid && ifa.req_ready) begin
        if (ifa.req_write) begin
          ref_mem[ifa.req_addr] = ifa.req_wdata;
          if (WACK) exp_q.push_back('{wr: 1'b1, data: 8'h00});
        end else begin
          exp_q.push_back('{wr: 1'b0, data: ref_mem[ifa.req_addr]});
          reads_acc++;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drain();
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    for (int n = 0; n < 20 && (exp_q.size() != 0 || ifa.busy); n++) cyc();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0;
    ifa.req_wdata = '0;   ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0;
    ifb.req_wdata = '0;   ifb.rsp_ready = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // reset state, with a write presented that must not reach the RAM
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h10; ifa.req_wdata = 8'hEE;
    sample();
    chk("reset_req_ready", 32'(ifa.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("reset_busy", 32'(ifa.busy), 32'd0);
    chk("reset_ram_we", 32'(ifa.ram_write_en), 32'd0);
    advance();

    // release: req_ready rises only on the following edge
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0;
    rstn = 1'b1;
    sample();
    chk("ready_before_edge", 32'(ifa.req_ready), 32'd0);
    advance();
    sample();
    chk("ready_after_edge", 32'(ifa.req_ready), 32'd1);
    advance();

    // write A5 @10 then read it back the next cycle
    ifa.rsp_ready = 1'b1;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h10; ifa.req_wdata = 8'hA5;
    sample();
    chk("wr_ram_we", 32'(ifa.ram_write_en), 32'd1);
    chk("wr_ram_addr", 32'(ifa.ram_addr), 32'h10);
    chk("wr_ram_din", 32'(ifa.ram_din), 32'hA5);
    advance();
    ifa.req_write = 1'b0;
    sample();
    chk("rd_ram_we", 32'(ifa.ram_write_en), 32'd0);
    chk("rd_ready", 32'(ifa.req_ready), 32'd1);
    advance();
    ifa.req_valid = 1'b0;
    for (int k = 1; k <= LAT_A; k++) begin
      sample();
      chk("rd_latency_wait", 32'(ifa.rsp_valid), 32'(WACK && k == LAT_A));
      if (k == 1) chk("busy_inflight", 32'(ifa.busy), 32'd1);
      advance();
    end
    sample();
    chk("rd_latency_valid", 32'(ifa.rsp_valid), 32'd1);
    advance();
    drain();

    // fill 0..7, then back-to-back reads with rsp_ready held high
    for (int i = 0; i < 8; i++) begin
      ifa.req_valid = 1'b1; ifa.req_write = 1'b1;
      ifa.req_addr = 8'(i); ifa.req_wdata = 8'(8'h30 + i);
      cyc();
    end
    for (int i = 0; i < LAT_A + 10; i++) begin
      ifa.req_valid = (i < 8); ifa.req_write = 1'b0; ifa.req_addr = 8'(i);
      sample();
      if (i < 8) chk("tp_req_ready", 32'(ifa.req_ready), 32'd1);
      chk("tp_rsp_valid", 32'(ifa.rsp_valid),
          32'((i >= LAT_A + 1 && i <= LAT_A + 8) || (WACK && i <= LAT_A)));
      advance();
    end
    drain();

    // backpressure: exactly RSP_A reads accepted, ready returns after first pop
    ifa.rsp_ready = 1'b0;
    reads_acc = 0;
    for (int i = 0; i < RSP_A + 3; i++) begin
      ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 8'(i);
      sample();
      chk("bp_req_ready", 32'(ifa.req_ready), 32'(i < RSP_A));
      advance();
    end
    chk("bp_accepted", 32'(reads_acc), 32'(RSP_A));
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    sample();
    chk("bp_full_ready", 32'(ifa.req_ready), 32'd0);
    chk("bp_head_valid", 32'(ifa.rsp_valid), 32'd1);
    advance();
    sample();
    chk("bp_ready_back", 32'(ifa.req_ready), 32'd1);
    advance();
    drain();

    // reset with two reads in flight and one beat queued
    ifa.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 8'(i);
      cyc();
    end
    ifa.req_valid = 1'b0;
    sample();
    chk("pre_rst_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
    chk("pre_rst_busy", 32'(ifa.busy), 32'd1);
    #1 rstn = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h55; ifa.req_wdata = 8'hCC;
    #1;
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_ram_we", 32'(ifa.ram_write_en), 32'd0);
    exp_q.delete();
    advance();
    advance();
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0;
    rstn = 1'b1;
    advance();
    ifa.rsp_ready = 1'b1;
    for (int k = 0; k < LAT_A + 3; k++) begin
      sample();
      chk("no_stale_beat", 32'(ifa.rsp_valid), 32'd0);
      advance();
    end
    b0 = beats;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h20; ifa.req_wdata = 8'h77;
    cyc();
    ifa.req_write = 1'b0;
    cyc();
    drain();
    chk("fresh_beats", 32'(beats - b0), 32'(1 + int'(WACK)));

    // LATENCY=0 instance: store 5A @3F, read it, data on the next cycle
    ifb.rsp_ready = 1'b1;
    ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_addr = 8'h3F; ifb.req_wdata = 8'h5A;
    sample();
    chk("b_req_ready", 32'(ifb.req_ready), 32'd1);
    advance();
    ifb.req_write = 1'b0;
    sample();
    chk("b_write_beat", 32'(ifb.rsp_valid), 32'(WACK));
    advance();
    ifb.req_valid = 1'b0;
    sample();
    chk("b_rsp_valid", 32'(ifb.rsp_valid), 32'd1);
    chk("b_rsp_data", 32'(ifb.rsp_data), 32'h5A);
`ifdef MEM_REQUESTER_WRITE_ACK_EN
    chk("b_rsp_write", 32'(ifb.rsp_write), 32'd0);
`endif
    advance();
    sample();
    chk("b_idle_valid", 32'(ifb.rsp_valid), 32'd0);
    chk("b_idle_busy", 32'(ifb.busy), 32'd0);
    advance();

`ifdef MEM_REQUESTER_WRITE_ACK_EN
    // write, read, write: three beats flagged 1,0,1 with data 0, mem, 0
    b0 = beats;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 8'h40; ifa.req_wdata = 8'h11;
    cyc();
    ifa.req_write = 1'b0;
    cyc();
    ifa.req_write = 1'b1; ifa.req_addr = 8'h41; ifa.req_wdata = 8'h22;
    cyc();
    drain();
    chk("wack_beats", 32'(beats - b0), 32'd3);
`endif

    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
